// File: rtl/ma_dcache.sv
// Direct-mapped write-through no-write-allocate MA-stage data cache.
// Optional load hit/miss counters under `DCACHE_PERF_CNT_EN.
module ma_dcache #(
  parameter int NUM_LINES = 64,
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req,
  input  logic                 i_store,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic [3:0]           i_be,
  input  logic                 i_flush,
  output logic                 o_ready,
  output logic [DATA_SIZE-1:0] o_rdata,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [DATA_SIZE-1:0] o_mem_wdata,
  output logic [3:0]           o_mem_be,
  input  logic                 i_mem_ack,
  input  logic [DATA_SIZE-1:0] i_mem_rdata,
  output logic [31:0]          o_hit_count,
  output logic [31:0]          o_miss_count
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_SIZE - 2 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_SIZE-1:0] data_q [NUM_LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             unused_bits;

  assign idx         = i_addr[2 +: IDX_W];
  assign tag         = i_addr[ADDR_SIZE-1 -: TAG_W];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_bits = ^i_addr[1:0];

  always_comb begin
    o_ready = 1'b0;
    o_rdata = '0;
    unique case (state)
      IDLE: begin
        o_ready = ~i_req | (~i_store & hit);
        if (i_req && !i_store && hit) o_rdata = data_q[idx];
      end
      FILL:  o_ready = 1'b0;
      WRITE: o_ready = 1'b0;
      DONE:  o_ready = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      valid_q     <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= '0;
    end else begin
      if (i_flush) valid_q <= '0;
      unique case (state)
        IDLE: begin
          if (i_req && i_store) begin
            state       <= WRITE;
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b1;
            o_mem_addr  <= {i_addr[ADDR_SIZE-1:2], 2'b00};
            o_mem_wdata <= i_wdata;
            o_mem_be    <= i_be;
          end else if (i_req && !hit) begin
            state      <= FILL;
            o_mem_req  <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= {i_addr[ADDR_SIZE-1:2], 2'b00};
            o_mem_be   <= 4'hF;
          end
        end
        FILL: begin
          if (i_mem_ack) begin
            // Overrides a same-cycle flush: the filled line survives.
            valid_q[idx] <= 1'b1;
            state        <= IDLE;
            o_mem_req    <= 1'b0;
            o_mem_be     <= '0;
          end
        end
        WRITE: begin
          if (i_mem_ack) begin
            state     <= DONE;
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            o_mem_be  <= '0;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == FILL && i_mem_ack) begin
      data_q[idx] <= i_mem_rdata;
      tag_q[idx]  <= tag;
    end else if (state == WRITE && i_mem_ack && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) data_q[idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE && i_req && !i_store) begin
      if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign o_hit_count  = hit_cnt;
  assign o_miss_count = miss_cnt;
`else
  assign o_hit_count  = '0;
  assign o_miss_count = '0;
`endif

endmodule
